byte_logic_bist: RTL and testbench

//  Built-in stimulus/checker for the cpu_v1 byte-wide logic units (byte_and, XOR, buffer).

---
 rtl/byte_logic_pkg.sv | 37 +++
 rtl/byte_lfsr.sv | 41 ++++
 rtl/byte_logic_bist.sv | 155 +++++++++++++++
 tb/tb_byte_logic_bist.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/byte_logic_pkg.sv
// Shared definitions for the byte logic BIST: op encodings, LFSR taps,
// FSM states and the golden model used to judge the unit under test.
package byte_logic_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b01;
   localparam logic [1:0] OP_BUF = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   // Taps for x^8+x^6+x^5+x^4+1 as bit positions 7,5,4,3 of the shift register
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } bist_state_e;

   function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

   function automatic logic [7:0] byte_logic_ref(input logic [1:0] op,
                                                 input logic [7:0] a,
                                                 input logic [7:0] b);
      logic [7:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_XOR:  r = a ^ b;
         OP_BUF:  r = a;
         OP_OR:   r = a | b;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/byte_lfsr.sv
// 8-bit Fibonacci LFSR operand generator with seed load and step enable.
module byte_lfsr
   import byte_logic_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next-state selection: seed load wins over stepping
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = SEED;
      end else if (en) begin
         q_d = lfsr8_next(q_q);
      end else begin
         q_d = q_q;
      end
   end

   // State register; reset clears to zero so the operand outputs read 0 in reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= {WIDTH{1'b0}};
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/byte_logic_bist.sv
// Self-test sequencer for byte-wide logic units: drives LFSR operands, compares
// the unit's result to the golden model and records the first failing vector.
module byte_logic_bist
   import byte_logic_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               NUM_VECTORS = 256,
   parameter logic [WIDTH-1:0] SEED_A      = 8'h0F,
   parameter logic [WIDTH-1:0] SEED_B      = 8'h0A
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op_sel,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   input  logic [WIDTH-1:0] dut_o,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       err_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH-1:0] fail_o
);

   localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

   bist_state_e      state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [15:0]      vec_cnt_q, vec_cnt_d;
   logic [7:0]       err_q, err_d;
   logic [WIDTH-1:0] fail_a_q, fail_a_d;
   logic [WIDTH-1:0] fail_b_q, fail_b_d;
   logic [WIDTH-1:0] fail_o_q, fail_o_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_s;
   logic             en_s;
   logic             mismatch_s;
   logic             last_s;

   byte_lfsr #(.WIDTH(WIDTH), .SEED(SEED_A)) u_lfsr_a (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s),
      .en    (en_s),
      .q     (dut_a)
   );

   byte_lfsr #(.WIDTH(WIDTH), .SEED(SEED_B)) u_lfsr_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s),
      .en    (en_s),
      .q     (dut_b)
   );

   // Sequencer next-state, compare and first-failure capture
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      vec_cnt_d  = vec_cnt_q;
      err_d      = err_q;
      fail_a_d   = fail_a_q;
      fail_b_d   = fail_b_q;
      fail_o_d   = fail_o_q;
      busy_d     = busy_q;
      done_d     = done_q;
      load_s     = 1'b0;
      en_s       = 1'b0;
      mismatch_s = (dut_o != byte_logic_ref(op_q, dut_a, dut_b));
      last_s     = (vec_cnt_q == LAST_VEC);
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load_s    = 1'b1;
               op_d      = op_sel;
               vec_cnt_d = 16'd0;
               err_d     = 8'h00;
               fail_a_d  = {WIDTH{1'b0}};
               fail_b_d  = {WIDTH{1'b0}};
               fail_o_d  = {WIDTH{1'b0}};
               busy_d    = 1'b1;
               done_d    = 1'b0;
               state_d   = ST_CHECK;
            end else begin
               state_d = state_q;
            end
         end
         ST_CHECK: begin
            if (mismatch_s) begin
               if (err_q == 8'h00) begin
                  fail_a_d = dut_a;
                  fail_b_d = dut_b;
                  fail_o_d = dut_o;
               end else begin
                  fail_a_d = fail_a_q;
               end
               err_d = (err_q == 8'hFF) ? 8'hFF : (err_q + 8'd1);
            end else begin
               err_d = err_q;
            end
            // Operands stop stepping on the last vector so they remain visible after the run
            if (last_s) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               en_s      = 1'b1;
               vec_cnt_d = vec_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // FSM and result registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= 2'b00;
         vec_cnt_q <= 16'd0;
         err_q     <= 8'h00;
         fail_a_q  <= {WIDTH{1'b0}};
         fail_b_q  <= {WIDTH{1'b0}};
         fail_o_q  <= {WIDTH{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         vec_cnt_q <= vec_cnt_d;
         err_q     <= err_d;
         fail_a_q  <= fail_a_d;
         fail_b_q  <= fail_b_d;
         fail_o_q  <= fail_o_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = done_q && (err_q == 8'h00);
   assign err_count = err_q;
   assign fail_a    = fail_a_q;
   assign fail_b    = fail_b_q;
   assign fail_o    = fail_o_q;

endmodule

// File: tb/tb_byte_logic_bist.sv
// Directed bench for byte_logic_bist: a reference model fills a scoreboard at
// each start, and operands/results are popped and compared as the run proceeds.
module tb_byte_logic_bist;

   typedef struct packed {
      logic [7:0] err;
      logic [7:0] fa;
      logic [7:0] fb;
      logic [7:0] fo;
      logic [7:0] la;
      logic [7:0] lb;
   } res_t;

   logic       clk;
   logic       rst_n;
   logic       start4, start300;
   logic [1:0] op_sel;
   logic [1:0] run_op;
   int         mode;
   bit         use300;

   logic [7:0] a4, b4, o4, err4, fa4, fb4, fo4;
   logic       busy4, done4, pass4;
   logic [7:0] a300, b300, o300, err300, fa300, fb300, fo300;
   logic       busy300, done300, pass300;

   logic [7:0] obs_a, obs_b, obs_err, obs_fa, obs_fb, obs_fo;
   logic       obs_busy, obs_done, obs_pass;

   int total = 0;
   int bad   = 0;

   logic [15:0] vec_q[$];
   res_t        res_q[$];

   function automatic logic [7:0] m_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   function automatic logic [7:0] m_ref(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a ^ b;
         2'b10:   return a;
         default: return a | b;
      endcase
   endfunction

   // Unit-under-test stand-ins: 0 correct, 1 stuck zero, 2 XNOR, 3 wrong except first vector
   function automatic logic [7:0] stub(input int md, input logic [1:0] op,
                                       input logic [7:0] a, input logic [7:0] b);
      case (md)
         0:       return m_ref(op, a, b);
         1:       return 8'h00;
         2:       return ~(a ^ b);
         default: return (a != 8'h0F) ? (m_ref(op, a, b) ^ 8'h01) : m_ref(op, a, b);
      endcase
   endfunction

   assign o4   = stub(mode, run_op, a4, b4);
   assign o300 = stub(mode, run_op, a300, b300);

   byte_logic_bist #(.WIDTH(8), .NUM_VECTORS(4), .SEED_A(8'h0F), .SEED_B(8'h0A)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .op_sel(op_sel),
      .dut_a(a4), .dut_b(b4), .dut_o(o4), .busy(busy4), .done(done4), .pass(pass4),
      .err_count(err4), .fail_a(fa4), .fail_b(fb4), .fail_o(fo4)
   );

   byte_logic_bist #(.WIDTH(8), .NUM_VECTORS(300), .SEED_A(8'h0F), .SEED_B(8'h0A)) u_dut300 (
      .clk(clk), .rst_n(rst_n), .start(start300), .op_sel(op_sel),
      .dut_a(a300), .dut_b(b300), .dut_o(o300), .busy(busy300), .done(done300), .pass(pass300),
      .err_count(err300), .fail_a(fa300), .fail_b(fb300), .fail_o(fo300)
   );

   always_comb begin
      obs_a    = use300 ? a300    : a4;
      obs_b    = use300 ? b300    : b4;
      obs_err  = use300 ? err300  : err4;
      obs_fa   = use300 ? fa300   : fa4;
      obs_fb   = use300 ? fb300   : fb4;
      obs_fo   = use300 ? fo300   : fo4;
      obs_busy = use300 ? busy300 : busy4;
      obs_done = use300 ? done300 : done4;
      obs_pass = use300 ? pass300 : pass4;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (use300) start300 = v;
      else        start4   = v;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {61'd0, obs_busy, obs_done, obs_pass}, 64'd0);
      chk({tag, "_dat"}, {obs_err, obs_a, obs_b, obs_fa, obs_fb, obs_fo}, 64'd0);
   endtask

   // One run: model fills the scoreboard, then operands and final results are popped
   task automatic run_test(input string tag, input int n, input int md,
                           input logic [1:0] op, input bit toggle_op);
      logic [7:0] a, b, o, err, fa, fb, fo;
      logic [15:0] v;
      res_t r;
      int cyc;
      a = 8'h0F; b = 8'h0A; err = 8'h00; fa = 8'h00; fb = 8'h00; fo = 8'h00;
      for (int i = 0; i < n; i++) begin
         vec_q.push_back({a, b});
         o = stub(md, op, a, b);
         if (o !== m_ref(op, a, b)) begin
            if (err == 8'h00) begin fa = a; fb = b; fo = o; end
            if (err != 8'hFF) err = err + 8'd1;
         end
         if (i != n - 1) begin a = m_next(a); b = m_next(b); end
      end
      res_q.push_back('{err: err, fa: fa, fb: fb, fo: fo, la: a, lb: b});

      mode = md; run_op = op; op_sel = op;
      set_start(1'b1);
      @(posedge clk);
      @(negedge clk);
      if (!toggle_op) set_start(1'b0);
      chk({tag, "_entry"}, {obs_busy, obs_done, obs_err, obs_fa, obs_fb, obs_fo},
          {1'b1, 1'b0, 32'd0});
      cyc = 0;
      while (!obs_done && cyc < n + 20) begin
         if (obs_busy && vec_q.size() > 0) begin
            v = vec_q.pop_front();
            chk({tag, "_ops"}, {obs_a, obs_b}, v);
         end
         cyc++;
         if (toggle_op) op_sel = op_sel ^ 2'b11;
         @(negedge clk);
      end
      set_start(1'b0);
      op_sel = op;
      chk({tag, "_len"}, cyc, n);
      chk({tag, "_flags"}, {obs_done, obs_busy, vec_q.size() == 0}, {1'b1, 1'b0, 1'b1});
      vec_q.delete();
      r = res_q.pop_front();
      chk({tag, "_err"}, obs_err, r.err);
      chk({tag, "_pass"}, obs_pass, r.err == 8'h00);
      chk({tag, "_fail"}, {obs_fa, obs_fb, obs_fo}, {r.fa, r.fb, r.fo});
      chk({tag, "_hold"}, {obs_a, obs_b}, {r.la, r.lb});
   endtask

   initial begin
      rst_n = 1'b0; start4 = 1'b0; start300 = 1'b0; op_sel = 2'b00; run_op = 2'b00;
      mode = 0; use300 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("rst4");
      use300 = 1'b1;
      chk_zero("rst300");
      use300 = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      run_test("and_ok", 4, 0, 2'b00, 1'b0);
      run_test("stub0", 4, 1, 2'b00, 1'b0);
      run_test("buf0", 4, 1, 2'b10, 1'b0);

      use300 = 1'b1;
      run_test("sat300", 300, 2, 2'b01, 1'b0);
      chk("sat_ff", obs_err, 8'hFF);
      use300 = 1'b0;

      run_test("op_hold", 4, 0, 2'b11, 1'b1);

      // Reset while vector 2 is on the operands
      mode = 0; run_op = 2'b00; op_sel = 2'b00; start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_abort_busy", obs_busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_zero("abort");
      @(negedge clk);
      chk_zero("abort_idle");
      run_test("rerun", 4, 0, 2'b00, 1'b0);

      run_test("err3", 4, 3, 2'b00, 1'b0);
      chk("err3_cnt", obs_err, 8'd3);
      run_test("restart", 4, 0, 2'b01, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
